// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB manager: FSM state encoding, bus widths
// and the slot-index width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    // A single subordinate still gets a 1-bit index so vectors never collapse to zero width.
    function automatic int slot_idx_w(input int n);
        if (n > 1) return $clog2(n);
        return 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps a byte address onto one of NUM_SLV
// equally sized windows above BASE_ADDR, producing hit, one-hot select and index.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NUM_SLV   = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int                SLV_WIN_W = 12,
    localparam int               IDX_W     = slot_idx_w(NUM_SLV)
) (
    input  logic [APB_AW-1:0]  addr,
    output logic               hit,
    output logic [NUM_SLV-1:0] sel,
    output logic [IDX_W-1:0]   idx
);

    localparam int SEL_W   = (NUM_SLV > 1) ? IDX_W : 0;
    localparam int TAG_LSB = SLV_WIN_W + SEL_W;

    logic tag_match;
    logic idx_ok;
    logic unused_offset;

    assign tag_match = (addr[APB_AW-1:TAG_LSB] == BASE_ADDR[APB_AW-1:TAG_LSB]);

    generate
        if (NUM_SLV > 1) begin : g_multi
            assign idx = addr[SLV_WIN_W +: IDX_W];
        end else begin : g_single
            assign idx = '0;
        end
    endgenerate

    // Non-power-of-two slot counts leave index codes with no subordinate behind them.
    assign idx_ok = ({{(32-IDX_W){1'b0}}, idx} < 32'(NUM_SLV));
    assign hit    = tag_match && idx_ok;

    always_comb begin
        sel = '0;
        if (hit) sel[idx] = 1'b1;
    end

    assign unused_offset = ^addr[TAG_LSB-1:0];

endmodule

// File: rtl/apb_manager_n.sv
// APB manager bridging a single-transfer CPU bus to NUM_SLV APB subordinates.
// Optional access timeout is compiled in with the APB_TIMEOUT_EN macro.
module apb_manager_n
    import apb_pkg::*;
#(
    parameter int                NUM_SLV     = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int                SLV_WIN_W   = 12,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      transfer,
    input  logic                      write,
    input  logic [APB_AW-1:0]         addr,
    input  logic [APB_DW-1:0]         wdata,
    output logic [APB_DW-1:0]         rdata,
    output logic                      ready,
    output logic                      error,
    output logic [APB_AW-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [APB_DW-1:0]         PWDATA,
    output logic                      PENABLE,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*APB_DW-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    output apb_state_e                state
);

    localparam int IDX_W = slot_idx_w(NUM_SLV);

    generate
        if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
            $error("apb_manager_n: NUM_SLV must be 1..16");
        end
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
            $error("apb_manager_n: TIMEOUT_CYC must be 1..65535");
        end
    endgenerate

    logic               dec_hit;
    logic [NUM_SLV-1:0] dec_sel;
    logic [IDX_W-1:0]   dec_idx;
    logic [IDX_W-1:0]   idx_q;
    logic               sel_ready;
    logic [APB_DW-1:0]  sel_rdata;
    logic               timed_out;

    apb_addr_decoder #(
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .SLV_WIN_W (SLV_WIN_W)
    ) u_decoder (
        .addr (addr),
        .hit  (dec_hit),
        .sel  (dec_sel),
        .idx  (dec_idx)
    );

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == i[IDX_W-1:0]) begin
                sel_ready = PREADY[i];
                sel_rdata = PRDATA[APB_DW*i +: APB_DW];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wait_cnt;
    assign timed_out = (wait_cnt == WAIT_LIMIT);
`else
    assign timed_out = 1'b0;
`endif

    // CPU handshake: transfer is a one-cycle strobe honoured only in IDLE; every
    // accepted strobe yields exactly one ready pulse, with error and rdata valid alongside it.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state   <= IDLE;
            idx_q   <= '0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PENABLE <= 1'b0;
            PSEL    <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            error   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        PADDR  <= addr;
                        PWRITE <= write;
                        PWDATA <= wdata;
                        idx_q  <= dec_idx;
                        if (dec_hit) begin
                            state <= SETUP;
                            PSEL  <= dec_sel;
                        end else begin
                            state <= RESP;
                            ready <= 1'b1;
                            error <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    // A ready arriving on the timeout cycle still completes normally.
                    if (sel_ready) begin
                        state   <= RESP;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        ready   <= 1'b1;
                        error   <= 1'b0;
                        rdata   <= PWRITE ? '0 : sel_rdata;
                    end else if (timed_out) begin
                        state   <= RESP;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        ready   <= 1'b1;
                        error   <= 1'b1;
                        rdata   <= '0;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    error <= 1'b0;
                    rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
